// File: rtl/generic_sram_bit_ctrl_if.sv
// Request/acknowledge bus between a client and generic_sram_bit_ctrl.
// The client drives the master modport; the controller takes the slave modport.
interface generic_sram_bit_ctrl_if #(
  parameter int DW = 140,
  parameter int AW = 10
);
  logic          req;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [DW-1:0] req_mask;
  logic          ack;
  logic [DW-1:0] rdata;

  modport master (
    output req, req_we, req_addr, req_wdata, req_mask,
    input  ack, rdata
  );

  modport slave (
    input  req, req_we, req_addr, req_wdata, req_mask,
    output ack, rdata
  );
endinterface

// File: rtl/generic_sram_bit_ctrl.sv
// Initiator for a masked single-port synchronous SRAM: turns req/ack accesses into
// registered n_cs/n_we/n_oe cycles. Macro SRAM_CTRL_CLR_EN adds a clear sweep.
module generic_sram_bit_ctrl #(
  parameter int DW = 140,
  parameter int DD = 1024,
  parameter int AW = 10
) (
  input  logic                  clk,
  input  logic                  n_p_reset,
  generic_sram_bit_ctrl_if.slave bus,
  input  logic                  clr_start,
  output logic                  clr_busy,
  output logic                  sram_n_cs,
  output logic                  sram_n_we,
  output logic                  sram_n_oe,
  output logic [DW-1:0]         sram_mask,
  output logic [AW-1:0]         sram_ad,
  output logic [DW-1:0]         sram_din,
  input  logic [DW-1:0]         sram_dout
);

`ifdef SRAM_CTRL_CLR_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WR     = 3'd1,
    RD     = 3'd2,
    RD_CAP = 3'd3,
    CLR    = 3'd4
  } state_e;

  localparam logic [AW-1:0] LAST_ADDR = AW'(DD - 1);
`else
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WR     = 2'd1,
    RD     = 2'd2,
    RD_CAP = 2'd3
  } state_e;

  logic unused_clr_s;
  assign unused_clr_s = clr_start | (DD == 0);
`endif

  state_e        state_q, state_d;
  logic          ack_q, ack_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          n_cs_q, n_cs_d;
  logic          n_we_q, n_we_d;
  logic          n_oe_q, n_oe_d;
  logic [DW-1:0] mask_q, mask_d;
  logic [AW-1:0] ad_q, ad_d;
  logic [DW-1:0] din_q, din_d;
  logic          clr_busy_q, clr_busy_d;

  // Next state and next registered outputs; SRAM strobes default to deselected.
  always_comb begin
    state_d    = state_q;
    ack_d      = 1'b0;
    rdata_d    = rdata_q;
    n_cs_d     = 1'b1;
    n_we_d     = 1'b1;
    n_oe_d     = 1'b1;
    mask_d     = mask_q;
    ad_d       = ad_q;
    din_d      = din_q;
    clr_busy_d = 1'b0;

    case (state_q)
      IDLE: begin
`ifdef SRAM_CTRL_CLR_EN
        if (clr_start) begin
          state_d    = CLR;
          n_cs_d     = 1'b0;
          n_we_d     = 1'b0;
          ad_d       = {AW{1'b0}};
          din_d      = {DW{1'b0}};
          mask_d     = {DW{1'b0}};
          clr_busy_d = 1'b1;
        end else
`endif
        // A request still high during the ack cycle belongs to the finished access.
        if (bus.req && !ack_q) begin
          ad_d   = bus.req_addr;
          din_d  = bus.req_wdata;
          mask_d = bus.req_mask;
          n_cs_d = 1'b0;
          if (bus.req_we) begin
            state_d = WR;
            n_we_d  = 1'b0;
          end else begin
            state_d = RD;
            n_oe_d  = 1'b0;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WR: begin
        state_d = IDLE;
        ack_d   = 1'b1;
      end
      RD: begin
        state_d = RD_CAP;
        n_oe_d  = 1'b0;
      end
      RD_CAP: begin
        state_d = IDLE;
        rdata_d = sram_dout;
        ack_d   = 1'b1;
      end
`ifdef SRAM_CTRL_CLR_EN
      CLR: begin
        if (ad_q == LAST_ADDR) begin
          state_d = IDLE;
        end else begin
          ad_d       = ad_q + AW'(1);
          n_cs_d     = 1'b0;
          n_we_d     = 1'b0;
          clr_busy_d = 1'b1;
        end
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset deselects the SRAM asynchronously.
  always_ff @(posedge clk or negedge n_p_reset) begin
    if (!n_p_reset) begin
      state_q    <= IDLE;
      ack_q      <= 1'b0;
      rdata_q    <= {DW{1'b0}};
      n_cs_q     <= 1'b1;
      n_we_q     <= 1'b1;
      n_oe_q     <= 1'b1;
      mask_q     <= {DW{1'b0}};
      ad_q       <= {AW{1'b0}};
      din_q      <= {DW{1'b0}};
      clr_busy_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ack_q      <= ack_d;
      rdata_q    <= rdata_d;
      n_cs_q     <= n_cs_d;
      n_we_q     <= n_we_d;
      n_oe_q     <= n_oe_d;
      mask_q     <= mask_d;
      ad_q       <= ad_d;
      din_q      <= din_d;
      clr_busy_q <= clr_busy_d;
    end
  end

  assign bus.ack   = ack_q;
  assign bus.rdata = rdata_q;
  assign clr_busy  = clr_busy_q;
  assign sram_n_cs = n_cs_q;
  assign sram_n_we = n_we_q;
  assign sram_n_oe = n_oe_q;
  assign sram_mask = mask_q;
  assign sram_ad   = ad_q;
  assign sram_din  = din_q;

endmodule
